ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
ID/EX pipeline stage directly upstream of the ALU. It registers decoded operands and control, resolves MEM/WB forwarding, and selects immediate or shamt sources to drive alu_src_a, alu_src_b, alu_ctrl and alu_signed. It also detects load-use hazards, inserts bubbles, and honours downstream stall and branch flush.

Parameters:
DATA_W, 32, datapath width (DATA_32_W)
REG_ADDR_W, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
id_valid  in  1  decode slot holds an instruction
id_rs_addr, id_rt_addr  in  5  source register indices
id_rs_data, id_rt_data  in  32  register-file read data
id_imm  in  16  instruction immediate
id_shamt  in  5  shift amount field
id_imm_zext  in  1  1 = zero-extend imm, 0 = sign-extend
id_src_a_sel  in  1  0 = rs, 1 = zero-extended shamt
id_src_b_sel  in  1  0 = rt, 1 = extended imm
id_alu_ctrl  in  t_alu_opcode  ALU operation
id_alu_signed  in  1  signed compare select
id_reg_write, id_mem_read, id_mem_write  in  1  instruction control
id_wr_addr  in  5  destination register
mem_fwd_en, wb_fwd_en  in  1  producer writes a register
mem_fwd_addr, wb_fwd_addr  in  5  producer destination
mem_fwd_data, wb_fwd_data  in  32  producer result
stall  in  1  downstream hold
flush  in  1  kill the EX-stage instruction
load_use_stall  out  1  to hazard unit; ID/IF must hold
ex_valid  out  1  EX slot valid
alu_src_a, alu_src_b  out  32  ALU operands
alu_ctrl  out  t_alu_opcode  ALU operation
alu_signed  out  1  signed select
ex_store_data  out  32  forwarded rt value for stores
ex_reg_write, ex_mem_read, ex_mem_write  out  1  gated by ex_valid
ex_wr_addr  out  5  destination register

Behaviour:
- Reset (async, rst=1):
  - All registers clear: ex_valid=0, all data and addresses 0, alu_ctrl=ALU_ADD, alu_signed=0.
  - Gated controls are therefore 0. load_use_stall=0.
- Latency: an instruction accepted at edge N drives the ALU outputs from edge N until the next capture.
- Edge priority, evaluated once per clock: flush > stall > load-use bubble > capture.
  - flush: ex_valid<=0; reg_write, mem_read and mem_write regs <=0. Applies even when stall=1.
  - stall (no flush): all EX regs hold. Exception: ex rs/rt data regs reload with their current forwarded values, so a producer retiring during the stall is not lost.
  - Bubble (load_use_stall=1, no stall/flush): ex_valid<=0 and control regs <=0. The ID instruction is not captured; upstream re-presents it next cycle.
  - Capture: all id_* fields load; ex_valid<=id_valid.
- load_use_stall (combinational) = ex_valid & ex_mem_read & (ex_wr_addr!=0) & id_valid & (ex_wr_addr==id_rs_addr | ex_wr_addr==id_rt_addr).
- Forwarding (combinational, per operand, using the registered rs/rt addresses):
  - If addr==0, use the register value (r0 is never forwarded).
  - Else if mem_fwd_en & mem_fwd_addr==addr, use mem_fwd_data (MEM wins over WB).
  - Else if wb_fwd_en & wb_fwd_addr==addr, use wb_fwd_data.
  - Else use the registered data.
  - The WB->ID same-cycle bypass belongs to the register file, not this block.
- Operand select:
  - alu_src_a = src_a_sel ? {27'b0, shamt} : fwd_rs.
  - alu_src_b = src_b_sel ? ext_imm : fwd_rt.
  - ext_imm = imm_zext ? {16'b0, imm} : {{16{imm[15]}}, imm}.
  - ex_store_data = fwd_rt always.
- ex_valid=0: ex_reg_write, ex_mem_read and ex_mem_write outputs are forced 0. Datapath outputs are don't-care but must not be X after reset.
- Reset mid-stall or mid-bubble: state is lost and the stage returns to empty; no pending capture survives.

Test Plan:
- Reset with id_valid=1 toggling: all outputs 0 and alu_ctrl=ALU_ADD while rst=1. First instruction appears one edge after rst falls.
- addi, imm=16'hFFFC, sign-extend, rs=r3 holding 10: alu_src_b=32'hFFFFFFFC, alu_src_a=10. With id_imm_zext=1: alu_src_b=32'h0000FFFC.
- EX rs=r5 (reg file data 1), MEM producer r5=7 and WB producer r5=9: alu_src_a=7. MEM disabled: 9. Producer address 0 with data 5 and rs=r0: alu_src_a=0.
- lw r4 in EX followed by add using rt=r4 in ID: load_use_stall=1 for one cycle and ex_valid=0 on the next edge. The add is then captured, with r4 supplied via MEM forwarding.
- stall=1 for 3 cycles while the WB producer of rt=r6 (data 32'h55) retires in cycle 1: after release, alu_src_b=32'h55.
- stall=1 and flush=1 on the same edge: ex_valid=0, ex_reg_write=0, ex_mem_write=0 after that edge.

Source files
------------

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: registers decoded fields, resolves MEM/WB forwarding,
// picks immediate/shamt sources for the ALU and raises load-use bubbles.
package ex_operand_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } t_alu_opcode;
endpackage

module ex_operand_stage
  import ex_operand_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs_addr,
  input  logic [REG_ADDR_W-1:0] id_rt_addr,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [15:0]           id_imm,
  input  logic [4:0]            id_shamt,
  input  logic                  id_imm_zext,
  input  logic                  id_src_a_sel,
  input  logic                  id_src_b_sel,
  input  t_alu_opcode           id_alu_ctrl,
  input  logic                  id_alu_signed,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic [REG_ADDR_W-1:0] id_wr_addr,
  input  logic                  mem_fwd_en,
  input  logic [REG_ADDR_W-1:0] mem_fwd_addr,
  input  logic [DATA_W-1:0]     mem_fwd_data,
  input  logic                  wb_fwd_en,
  input  logic [REG_ADDR_W-1:0] wb_fwd_addr,
  input  logic [DATA_W-1:0]     wb_fwd_data,
  input  logic                  stall,
  input  logic                  flush,
  output logic                  load_use_stall,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     alu_src_a,
  output logic [DATA_W-1:0]     alu_src_b,
  output t_alu_opcode           alu_ctrl,
  output logic                  alu_signed,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic [REG_ADDR_W-1:0] ex_wr_addr
);

  logic                  valid_q;
  logic [REG_ADDR_W-1:0] rs_addr_q, rt_addr_q, wr_addr_q;
  logic [DATA_W-1:0]     rs_data_q, rt_data_q;
  logic [15:0]           imm_q;
  logic [4:0]            shamt_q;
  logic                  imm_zext_q, src_a_sel_q, src_b_sel_q;
  t_alu_opcode           alu_ctrl_q;
  logic                  alu_signed_q;
  logic                  reg_write_q, mem_read_q, mem_write_q;

  logic [DATA_W-1:0]     fwd_rs, fwd_rt, ext_imm;

  // r0 is hard-wired, so it is never taken from a producer; MEM is younger than WB.
  function automatic logic [DATA_W-1:0] fwd_pick(
    input logic [REG_ADDR_W-1:0] addr,
    input logic [DATA_W-1:0]     reg_val,
    input logic                  m_en,
    input logic [REG_ADDR_W-1:0] m_addr,
    input logic [DATA_W-1:0]     m_data,
    input logic                  w_en,
    input logic [REG_ADDR_W-1:0] w_addr,
    input logic [DATA_W-1:0]     w_data
  );
    if (addr == '0)                  return reg_val;
    else if (m_en && m_addr == addr) return m_data;
    else if (w_en && w_addr == addr) return w_data;
    else                             return reg_val;
  endfunction

  always_comb begin
    fwd_rs = fwd_pick(rs_addr_q, rs_data_q, mem_fwd_en, mem_fwd_addr, mem_fwd_data,
                      wb_fwd_en, wb_fwd_addr, wb_fwd_data);
    fwd_rt = fwd_pick(rt_addr_q, rt_data_q, mem_fwd_en, mem_fwd_addr, mem_fwd_data,
                      wb_fwd_en, wb_fwd_addr, wb_fwd_data);
    ext_imm = imm_zext_q ? {{(DATA_W-16){1'b0}}, imm_q}
                         : {{(DATA_W-16){imm_q[15]}}, imm_q};
  end

  always_comb begin
    load_use_stall = valid_q && mem_read_q && (wr_addr_q != '0) && id_valid &&
                     ((wr_addr_q == id_rs_addr) || (wr_addr_q == id_rt_addr));
  end

  // During a stall the operand registers re-sample their forwarded view so a
  // producer that retires while we wait is not lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q      <= 1'b0;
      rs_addr_q    <= '0;
      rt_addr_q    <= '0;
      wr_addr_q    <= '0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      shamt_q      <= '0;
      imm_zext_q   <= 1'b0;
      src_a_sel_q  <= 1'b0;
      src_b_sel_q  <= 1'b0;
      alu_ctrl_q   <= ALU_ADD;
      alu_signed_q <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
    end else if (flush || (!stall && load_use_stall)) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (stall) begin
      rs_data_q <= fwd_rs;
      rt_data_q <= fwd_rt;
    end else begin
      valid_q      <= id_valid;
      rs_addr_q    <= id_rs_addr;
      rt_addr_q    <= id_rt_addr;
      wr_addr_q    <= id_wr_addr;
      rs_data_q    <= id_rs_data;
      rt_data_q    <= id_rt_data;
      imm_q        <= id_imm;
      shamt_q      <= id_shamt;
      imm_zext_q   <= id_imm_zext;
      src_a_sel_q  <= id_src_a_sel;
      src_b_sel_q  <= id_src_b_sel;
      alu_ctrl_q   <= id_alu_ctrl;
      alu_signed_q <= id_alu_signed;
      reg_write_q  <= id_reg_write;
      mem_read_q   <= id_mem_read;
      mem_write_q  <= id_mem_write;
    end
  end

  always_comb begin
    ex_valid      = valid_q;
    alu_src_a     = src_a_sel_q ? {{(DATA_W-5){1'b0}}, shamt_q} : fwd_rs;
    alu_src_b     = src_b_sel_q ? ext_imm : fwd_rt;
    alu_ctrl      = alu_ctrl_q;
    alu_signed    = alu_signed_q;
    ex_store_data = fwd_rt;
    ex_reg_write  = valid_q & reg_write_q;
    ex_mem_read   = valid_q & mem_read_q;
    ex_mem_write  = valid_q & mem_write_q;
    ex_wr_addr    = wr_addr_q;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus a
// randomized run against a transaction-level model of the EX slot.
module tb_ex_operand_stage;
  import ex_operand_pkg::*;

  logic        clk, rst;
  logic        id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_shamt, id_wr_addr;
  logic [31:0] id_rs_data, id_rt_data;
  logic [15:0] id_imm;
  logic        id_imm_zext, id_src_a_sel, id_src_b_sel, id_alu_signed;
  t_alu_opcode id_alu_ctrl;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        mem_fwd_en, wb_fwd_en;
  logic [4:0]  mem_fwd_addr, wb_fwd_addr;
  logic [31:0] mem_fwd_data, wb_fwd_data;
  logic        stall, flush;
  logic        load_use_stall, ex_valid, alu_signed;
  logic [31:0] alu_src_a, alu_src_b, ex_store_data;
  t_alu_opcode alu_ctrl;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic [4:0]  ex_wr_addr;

  int checks = 0;
  int failures = 0;

  ex_operand_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm(id_imm), .id_shamt(id_shamt), .id_imm_zext(id_imm_zext),
    .id_src_a_sel(id_src_a_sel), .id_src_b_sel(id_src_b_sel),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_signed(id_alu_signed),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_wr_addr(id_wr_addr),
    .mem_fwd_en(mem_fwd_en), .mem_fwd_addr(mem_fwd_addr), .mem_fwd_data(mem_fwd_data),
    .wb_fwd_en(wb_fwd_en), .wb_fwd_addr(wb_fwd_addr), .wb_fwd_data(wb_fwd_data),
    .stall(stall), .flush(flush), .load_use_stall(load_use_stall),
    .ex_valid(ex_valid), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_ctrl(alu_ctrl), .alu_signed(alu_signed), .ex_store_data(ex_store_data),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_wr_addr(ex_wr_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rs_data = 0; id_rt_data = 0;
    id_imm = 0; id_shamt = 0; id_imm_zext = 0; id_src_a_sel = 0; id_src_b_sel = 0;
    id_alu_ctrl = ALU_ADD; id_alu_signed = 0; id_reg_write = 0; id_mem_read = 0;
    id_mem_write = 0; id_wr_addr = 0;
    mem_fwd_en = 0; mem_fwd_addr = 0; mem_fwd_data = 0;
    wb_fwd_en = 0; wb_fwd_addr = 0; wb_fwd_data = 0;
    stall = 0; flush = 0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1;
    id_rs_addr = 3; id_rs_data = 32'hDEAD; id_rt_addr = 2; id_rt_data = 32'hBEEF;
    id_alu_ctrl = ALU_SUB; id_reg_write = 1; id_mem_write = 1; id_wr_addr = 7;
    for (int i = 0; i < 4; i++) begin
      id_valid = i[0];
      tick();
      checks++;
      if (ex_valid !== 1'b0 || alu_src_a !== 32'd0 || alu_src_b !== 32'd0 ||
          alu_ctrl !== ALU_ADD || alu_signed !== 1'b0 || ex_store_data !== 32'd0 ||
          ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || ex_mem_write !== 1'b0 ||
          ex_wr_addr !== 5'd0 || load_use_stall !== 1'b0) begin
        failures++;
        $display("[TB] FAIL reset_state: valid=%b a=%h b=%h ctrl=%0d rw=%b mw=%b wr=%0d lus=%b, required all zero / ALU_ADD",
                 ex_valid, alu_src_a, alu_src_b, alu_ctrl, ex_reg_write, ex_mem_write, ex_wr_addr, load_use_stall);
      end
    end
    id_valid = 1;
    rst = 0;
    #1;
    checks++;
    if (ex_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_release_before_edge: ex_valid=%b required 0", ex_valid);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b1 || alu_src_a !== 32'hDEAD || alu_ctrl !== ALU_SUB || ex_wr_addr !== 5'd7) begin
      failures++;
      $display("[TB] FAIL first_capture: valid=%b a=%h ctrl=%0d wr=%0d required 1/0000dead/%0d/7",
               ex_valid, alu_src_a, alu_ctrl, ex_wr_addr, ALU_SUB);
    end
  endtask

  task automatic test_imm_ext();
    set_idle();
    id_valid = 1; id_rs_addr = 3; id_rs_data = 10; id_src_b_sel = 1;
    id_imm = 16'hFFFC; id_imm_zext = 0; id_reg_write = 1; id_wr_addr = 8;
    tick();
    checks++;
    if (alu_src_a !== 32'd10 || alu_src_b !== 32'hFFFFFFFC || ex_reg_write !== 1'b1) begin
      failures++;
      $display("[TB] FAIL imm_sext: a=%h b=%h rw=%b required 0000000a/fffffffc/1", alu_src_a, alu_src_b, ex_reg_write);
    end
    id_imm_zext = 1;
    tick();
    checks++;
    if (alu_src_b !== 32'h0000FFFC) begin
      failures++;
      $display("[TB] FAIL imm_zext: b=%h required 0000fffc", alu_src_b);
    end
    id_src_a_sel = 1; id_shamt = 5'd31;
    tick();
    checks++;
    if (alu_src_a !== 32'd31) begin
      failures++;
      $display("[TB] FAIL shamt_select: a=%h required 0000001f", alu_src_a);
    end
  endtask

  task automatic test_forwarding();
    set_idle();
    id_valid = 1; id_rs_addr = 5; id_rs_data = 1; id_rt_addr = 5; id_rt_data = 1;
    tick();
    mem_fwd_en = 1; mem_fwd_addr = 5; mem_fwd_data = 7;
    wb_fwd_en = 1;  wb_fwd_addr = 5;  wb_fwd_data = 9;
    #1;
    checks++;
    if (alu_src_a !== 32'd7 || ex_store_data !== 32'd7) begin
      failures++;
      $display("[TB] FAIL fwd_mem_priority: a=%0d store=%0d required 7", alu_src_a, ex_store_data);
    end
    mem_fwd_en = 0;
    #1;
    checks++;
    if (alu_src_a !== 32'd9) begin
      failures++;
      $display("[TB] FAIL fwd_wb: a=%0d required 9", alu_src_a);
    end
    wb_fwd_en = 0;
    #1;
    checks++;
    if (alu_src_a !== 32'd1) begin
      failures++;
      $display("[TB] FAIL fwd_none: a=%0d required 1", alu_src_a);
    end
    id_rs_addr = 0; id_rs_data = 0;
    tick();
    mem_fwd_en = 1; mem_fwd_addr = 0; mem_fwd_data = 5;
    wb_fwd_en = 1;  wb_fwd_addr = 0;  wb_fwd_data = 5;
    #1;
    checks++;
    if (alu_src_a !== 32'd0) begin
      failures++;
      $display("[TB] FAIL fwd_r0_blocked: a=%0d required 0", alu_src_a);
    end
  endtask

  task automatic test_load_use();
    set_idle();
    id_valid = 1; id_rs_addr = 1; id_rs_data = 32'h100; id_src_b_sel = 1; id_imm = 4;
    id_mem_read = 1; id_reg_write = 1; id_wr_addr = 4; id_alu_ctrl = ALU_ADD;
    tick();
    id_rs_addr = 2; id_rs_data = 32'h20; id_rt_addr = 4; id_rt_data = 32'hBAD;
    id_src_b_sel = 0; id_mem_read = 0; id_wr_addr = 9; id_alu_ctrl = ALU_OR;
    #1;
    checks++;
    if (load_use_stall !== 1'b1 || ex_mem_read !== 1'b1) begin
      failures++;
      $display("[TB] FAIL load_use_detect: lus=%b mr=%b required 1/1", load_use_stall, ex_mem_read);
    end
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_read !== 1'b0 || load_use_stall !== 1'b0) begin
      failures++;
      $display("[TB] FAIL load_use_bubble: valid=%b rw=%b mr=%b lus=%b required 0/0/0/0",
               ex_valid, ex_reg_write, ex_mem_read, load_use_stall);
    end
    mem_fwd_en = 1; mem_fwd_addr = 4; mem_fwd_data = 32'h1234;
    tick();
    checks++;
    if (ex_valid !== 1'b1 || alu_src_b !== 32'h1234 || alu_src_a !== 32'h20 ||
        alu_ctrl !== ALU_OR || ex_wr_addr !== 5'd9) begin
      failures++;
      $display("[TB] FAIL load_use_recapture: valid=%b a=%h b=%h ctrl=%0d wr=%0d required 1/00000020/00001234/%0d/9",
               ex_valid, alu_src_a, alu_src_b, alu_ctrl, ex_wr_addr, ALU_OR);
    end
  endtask

  task automatic test_stall_forward();
    set_idle();
    id_valid = 1; id_rs_addr = 1; id_rs_data = 32'hA; id_rt_addr = 6; id_rt_data = 32'h11;
    id_reg_write = 1; id_wr_addr = 3;
    tick();
    id_rs_data = 32'hF00D; id_rt_data = 32'h77; id_wr_addr = 12;
    stall = 1; wb_fwd_en = 1; wb_fwd_addr = 6; wb_fwd_data = 32'h55;
    tick();
    wb_fwd_en = 0;
    tick();
    tick();
    checks++;
    if (ex_valid !== 1'b1 || alu_src_a !== 32'hA || ex_wr_addr !== 5'd3) begin
      failures++;
      $display("[TB] FAIL stall_hold: valid=%b a=%h wr=%0d required 1/0000000a/3", ex_valid, alu_src_a, ex_wr_addr);
    end
    stall = 0;
    #1;
    checks++;
    if (alu_src_b !== 32'h55) begin
      failures++;
      $display("[TB] FAIL stall_wb_retire: b=%h required 00000055", alu_src_b);
    end
  endtask

  task automatic test_stall_flush();
    set_idle();
    id_valid = 1; id_reg_write = 1; id_mem_write = 1; id_wr_addr = 2;
    tick();
    stall = 1; flush = 1;
    tick();
    checks++;
    if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_mem_write !== 1'b0) begin
      failures++;
      $display("[TB] FAIL stall_flush: valid=%b rw=%b mw=%b required 0/0/0", ex_valid, ex_reg_write, ex_mem_write);
    end
    stall = 0; flush = 0;
  endtask

  typedef struct {
    bit          valid;
    bit [4:0]    rs, rt, wr, shamt;
    bit [31:0]   rs_val, rt_val;
    bit [15:0]   imm;
    bit          zext, a_sel, b_sel, signed_cmp, rw, mr, mw;
    t_alu_opcode op;
  } slot_t;

  function automatic bit [31:0] ref_value(input bit [4:0] r, input bit [31:0] held);
    if (r == 0) return held;
    if (mem_fwd_en && mem_fwd_addr == r) return mem_fwd_data;
    if (wb_fwd_en && wb_fwd_addr == r) return wb_fwd_data;
    return held;
  endfunction

  task automatic test_random();
    slot_t m, nm;
    bit [31:0] ea, eb, ers, ert;
    bit elus;
    set_idle();
    rst = 1;
    tick();
    rst = 0;
    m.valid = 0; m.rs = 0; m.rt = 0; m.wr = 0; m.shamt = 0; m.rs_val = 0; m.rt_val = 0;
    m.imm = 0; m.zext = 0; m.a_sel = 0; m.b_sel = 0; m.signed_cmp = 0;
    m.rw = 0; m.mr = 0; m.mw = 0; m.op = ALU_ADD;
    for (int i = 0; i < 500; i++) begin
      id_valid = ($urandom % 4) != 0;
      id_rs_addr = 5'($urandom_range(0, 7)); id_rt_addr = 5'($urandom_range(0, 7));
      id_wr_addr = 5'($urandom_range(0, 7));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = 16'($urandom);
      id_shamt = 5'($urandom); id_imm_zext = 1'($urandom); id_src_a_sel = ($urandom % 4) == 0;
      id_src_b_sel = 1'($urandom); id_alu_ctrl = t_alu_opcode'($urandom_range(0, 10));
      id_alu_signed = 1'($urandom); id_reg_write = 1'($urandom);
      id_mem_read = ($urandom % 3) == 0; id_mem_write = ($urandom % 4) == 0;
      mem_fwd_en = 1'($urandom); mem_fwd_addr = 5'($urandom_range(0, 7)); mem_fwd_data = $urandom;
      wb_fwd_en = 1'($urandom);  wb_fwd_addr = 5'($urandom_range(0, 7));  wb_fwd_data = $urandom;
      stall = ($urandom % 6) == 0; flush = ($urandom % 10) == 0;
      #1;
      ers = ref_value(m.rs, m.rs_val);
      ert = ref_value(m.rt, m.rt_val);
      ea = m.a_sel ? {27'd0, m.shamt} : ers;
      eb = m.b_sel ? (m.zext ? {16'd0, m.imm} : {{16{m.imm[15]}}, m.imm}) : ert;
      elus = m.valid && m.mr && m.wr != 0 && id_valid && (m.wr == id_rs_addr || m.wr == id_rt_addr);
      checks++;
      if (ex_valid !== m.valid || alu_src_a !== ea || alu_src_b !== eb || alu_ctrl !== m.op ||
          alu_signed !== m.signed_cmp || ex_store_data !== ert || ex_wr_addr !== m.wr ||
          ex_reg_write !== (m.valid & m.rw) || ex_mem_read !== (m.valid & m.mr) ||
          ex_mem_write !== (m.valid & m.mw) || load_use_stall !== elus) begin
        failures++;
        $display("[TB] FAIL random_step %0d: got v=%b a=%h b=%h op=%0d sg=%b st=%h wr=%0d rw=%b mr=%b mw=%b lus=%b; want v=%b a=%h b=%h op=%0d sg=%b st=%h wr=%0d rw=%b mr=%b mw=%b lus=%b",
                 i, ex_valid, alu_src_a, alu_src_b, alu_ctrl, alu_signed, ex_store_data, ex_wr_addr,
                 ex_reg_write, ex_mem_read, ex_mem_write, load_use_stall,
                 m.valid, ea, eb, m.op, m.signed_cmp, ert, m.wr, m.valid & m.rw, m.valid & m.mr,
                 m.valid & m.mw, elus);
      end
      nm = m;
      if (flush || (!stall && elus)) begin
        nm.valid = 0; nm.rw = 0; nm.mr = 0; nm.mw = 0;
      end else if (stall) begin
        nm.rs_val = ers; nm.rt_val = ert;
      end else begin
        nm.valid = id_valid; nm.rs = id_rs_addr; nm.rt = id_rt_addr; nm.wr = id_wr_addr;
        nm.rs_val = id_rs_data; nm.rt_val = id_rt_data; nm.imm = id_imm; nm.shamt = id_shamt;
        nm.zext = id_imm_zext; nm.a_sel = id_src_a_sel; nm.b_sel = id_src_b_sel;
        nm.op = id_alu_ctrl; nm.signed_cmp = id_alu_signed;
        nm.rw = id_reg_write; nm.mr = id_mem_read; nm.mw = id_mem_write;
      end
      @(posedge clk);
      m = nm;
      #1;
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    rst = 1;
    test_reset();
    test_imm_ext();
    test_forwarding();
    test_load_use();
    test_stall_forward();
    test_stall_flush();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
